// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - shared types, constants and rotate helper for the immediate encoder
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int ROT_STEPS = 16;

  // Rotate left by 2*r; with r=0 the word passes through unchanged.
  function automatic logic [31:0] rol_even(input logic [31:0] x, input logic [3:0] r);
    logic [63:0] t;
    t = {x, x} << (2 * r);
    return t[63:32];
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/response handshake bundle for the immediate encoder
interface imm_encoder_if #(parameter int N = 32);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] value;
  logic         try_inv;
  logic         out_valid;
  logic         out_ready;
  logic [11:0]  imm12;
  logic         encodable;
  logic         inverted;
  logic         c_out;

  modport slave (
    input  in_valid, value, try_inv, out_ready,
    output in_ready, out_valid, imm12, encodable, inverted, c_out
  );

  modport master (
    output in_valid, value, try_inv, out_ready,
    input  in_ready, out_valid, imm12, encodable, inverted, c_out
  );

endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - iterative search for a rotated 8-bit immediate encoding of a 32-bit constant
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  imm_encoder_if.slave  bus
);

  state_e        state_q, state_d;
  logic [N-1:0]  value_q, value_d;
  logic          try_inv_q, try_inv_d;
  logic [3:0]    r_q, r_d;
  logic          p_q, p_d;
  logic [11:0]   imm12_q, imm12_d;
  logic          encodable_q, encodable_d;
  logic          inverted_q, inverted_d;
  logic          c_out_q, c_out_d;

  logic [N-1:0]  cand;
  logic [31:0]   rot;
  logic          hit;

  // One rotation amount per cycle; the candidate flips to ~value on the second pass.
  assign cand = p_q ? ~value_q : value_q;
  assign rot  = rol_even(cand, r_q);
  assign hit  = (rot[31:8] == 24'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      value_q     <= '0;
      try_inv_q   <= 1'b0;
      r_q         <= 4'd0;
      p_q         <= 1'b0;
      imm12_q     <= 12'd0;
      encodable_q <= 1'b0;
      inverted_q  <= 1'b0;
      c_out_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      try_inv_q   <= try_inv_d;
      r_q         <= r_d;
      p_q         <= p_d;
      imm12_q     <= imm12_d;
      encodable_q <= encodable_d;
      inverted_q  <= inverted_d;
      c_out_q     <= c_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    try_inv_d   = try_inv_q;
    r_d         = r_q;
    p_d         = p_q;
    imm12_d     = imm12_q;
    encodable_d = encodable_q;
    inverted_d  = inverted_q;
    c_out_d     = c_out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          value_d   = bus.value;
          try_inv_d = bus.try_inv;
          r_d       = 4'd0;
          p_d       = 1'b0;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          state_d     = DONE;
          imm12_d     = {r_q, rot[7:0]};
          encodable_d = 1'b1;
          inverted_d  = p_q;
          // Decoded operand equals the candidate, so its MSB is the shifter carry.
          c_out_d     = (r_q != 4'd0) && cand[31];
        end else if (r_q != 4'(ROT_STEPS - 1)) begin
          r_d = r_q + 4'd1;
        end else if (!p_q && try_inv_q) begin
          p_d = 1'b1;
          r_d = 4'd0;
        end else begin
          state_d     = DONE;
          imm12_d     = 12'd0;
          encodable_d = 1'b0;
          inverted_d  = 1'b0;
          c_out_d     = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.imm12     = imm12_q;
  assign bus.encodable = encodable_q;
  assign bus.inverted  = inverted_q;
  assign bus.c_out     = c_out_q;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter N, default 32, the data width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a request is present on value/try_inv.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port value, input, N bits: the constant to encode as a data-processing immediate.
REQ-007 SHALL have port try_inv, input, 1 bit: on a miss, retry with ~value (MOV/MVN swap).
REQ-008 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port imm12, output, 12 bits: {rot[3:0], imm8[7:0]}, which the operand-2 shifter decodes as ror(imm8, 2*rot).
REQ-011 SHALL have port encodable, output, 1 bit: imm12 is valid.
REQ-012 SHALL have port inverted, output, 1 bit: imm12 encodes ~value.
REQ-013 SHALL have port c_out, output, 1 bit: shifter carry, equal to the decoded bit 31 when rot!=0, else 0.

Function
REQ-014 SHALL implement states IDLE, SEARCH and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, on in_valid&&in_ready, register value and try_inv, clear rot counter r=0 and pass flag p=0, and go to SEARCH.
REQ-016 SHALL, each SEARCH cycle, test candidate cand=(p ? ~value_q : value_q), hit when rol(cand, 2r)[31:8]==0.
REQ-017 SHALL, on a hit, go to DONE with imm12={r, rol(cand,2r)[7:0]}, encodable=1 and inverted=p.
REQ-018 SHALL, on a miss with r<15, increment r.
REQ-019 SHALL, on a miss with r==15 and p==0 and try_inv_q==1, set p=1 and r=0.
REQ-020 SHALL, on a miss otherwise, go to DONE with encodable=0, imm12=0, inverted=0 and c_out=0.
REQ-021 SHALL select the smallest r within the first successful pass; value 0 encodes as imm12=0x000.
REQ-022 SHALL give latency from the accept edge to the edge asserting out_valid of r+1 (pass 0 hit) or 16+r+1 (pass 1 hit); a full miss SHALL take 16 or 32 edges.
REQ-023 SHALL hold imm12, encodable, inverted and c_out stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on out_valid&&out_ready, return to IDLE, so in_ready=1 the next cycle; there SHALL be no same-cycle accept in DONE.
REQ-025 SHALL ignore in_valid and value changes outside IDLE.

Reset
REQ-026 SHALL, with rst high at a clock edge, force IDLE, r=0, p=0, out_valid=0, imm12=0, encodable=0, inverted=0, c_out=0, and make in_ready=1 from the next cycle.
REQ-027 SHALL, on reset mid-SEARCH or in DONE, abandon the request with no result emitted.

Structure
REQ-028 SHALL place the state enum, ROT_STEPS=16 and the rol-by-even-amount helper function in a shared package, used by both this block and its bench.
REQ-029 SHALL be a single module with no sub-module; the hit test is inline combinational logic on the registered candidate.

Verification
REQ-030 SHALL test value=0x000000FF, try_inv=0 -> imm12=0x0FF, encodable=1, inverted=0, c_out=0, out_valid 1 edge after accept.
REQ-031 SHALL test value=0xF000000F -> imm12=0x2FF, c_out=1, latency 3; and value=0xFF000000 -> imm12=0x4FF, c_out=1, latency 5.
REQ-032 SHALL test value=0x00000102, try_inv=0 -> encodable=0, imm12=0x000, latency 16; with try_inv=1 -> encodable=0, latency 32.
REQ-033 SHALL test value=0xFFFFFF00, try_inv=1 -> imm12=0x0FF, inverted=1, encodable=1, latency 17.
REQ-034 SHALL test out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; then handshake -> in_ready=1 next cycle.
REQ-035 SHALL test rst pulsed at SEARCH r=7 -> next cycle out_valid=0, in_ready=1; a new request then completes normally.
REQ-036 SHALL include a random round-trip check: every encodable result, decoded as ror(imm8, 2*rot) and complemented if inverted, equals value.
